gcd_seq_ctrl: RTL and testbench
===============================

// Module: gcd_seq_ctrl
// PURPOSE
//  Multi-cycle GCD engine: controller sequences a compare/subtract step datapath (Euclid by repeated subtraction).
//  Latches two unsigned operands on start, iterates one subtract per clock, then returns the GCD with a one-cycle done pulse.
//  Sequential replacement for the combinational GCD path; sits between operand source and result consumer.
// PARAMETERS
//  WIDTH   4   operand/result width in bits (unsigned)
//  CNT_W   WIDTH+1   width of iteration counter (must hold 2^WIDTH-1)
// PORTS
//  clk       in   1       single clock; all state updates on rising edge
//  rst       in   1       synchronous, active-high reset
//  start     in   1       request; sampled only in IDLE
//  a_in      in   WIDTH   operand A, sampled with start
//  b_in      in   WIDTH   operand B, sampled with start
//  busy      out  1       high whenever state != IDLE
//  done      out  1       one-cycle pulse: gcd_out/iter_cnt valid
//  gcd_out   out  WIDTH   result; held until next accepted start or reset
//  iter_cnt  out  CNT_W   number of CALC cycles used by last operation
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, gcd_out=0, iter_cnt=0, internal a_r/b_r=0. Reset wins over every other event, incl. mid-CALC.
//  States: IDLE, CALC, DONE (2-bit encoding from package).
//  IDLE: start=1 and a_in!=0 and b_in!=0 -> a_r<=a_in, b_r<=b_in, cnt<=0, go CALC.
//        start=1 and (a_in==0 or b_in==0) -> gcd_out<=a_in|b_in, iter_cnt<=0, go DONE (gcd(0,0)=0).
//        start=0 -> stay; outputs hold.
//  CALC (one step per clock, cnt<=cnt+1 every CALC cycle):
//        a_r>b_r -> a_r<=a_r-b_r;  b_r>a_r -> b_r<=b_r-a_r;
//        a_r==b_r -> gcd_out<=a_r, iter_cnt<=cnt+1, go DONE.
//  DONE: done=1 for exactly this cycle; next edge -> IDLE unconditionally.
//  start while busy (CALC or DONE) is ignored, not queued; a_in/b_in changes while busy have no effect.
//  Subtraction never underflows (only larger minus smaller); no carry/borrow output. Operands nonzero in CALC so loop always terminates.
//  Latency (start edge to done high): nonzero operands = iterations+1 cycles; zero operand = 1 cycle.
//  Worst case (2^WIDTH-1, 1): 2^WIDTH-1 CALC cycles (15 for WIDTH=4).
//  gcd_out/iter_cnt update only at CALC->DONE or IDLE zero-path; stable otherwise.
//  Outputs registered; done decoded from state register (no combinational path from start).
// STRUCTURE
//  Package gcd_pkg: WIDTH default, state localparams ST_IDLE=2'd0, ST_CALC=2'd1, ST_DONE=2'd2.
//  Sub-module gcd_sub_step (combinational): in a,b -> out a_gt_b, b_gt_a, a_eq_b, a_next, b_next.
//  gcd_seq_ctrl holds FSM, a_r/b_r, counter, output registers; instantiates one gcd_sub_step.
//  State 2'd3 unreachable; decode to IDLE.
// TESTING
//  (12,8): start 1 cycle -> 3 CALC cycles, done 4 cycles after start edge, gcd_out=4, iter_cnt=3.
//  (15,1): gcd_out=1, iter_cnt=15, busy high 16 cycles, done single-cycle.
//  (9,9): 1 CALC cycle, gcd_out=9, iter_cnt=1; then (0,6) -> done next cycle, gcd_out=6, iter_cnt=0; (0,0) -> gcd_out=0.
//  (14,10) started, start pulsed with (3,3) during CALC and in DONE -> ignored; result gcd_out=2, no second done.
//  (15,1) started, rst=1 at 5th CALC cycle -> next edge busy=0, done=0, gcd_out=0, iter_cnt=0; then (6,4) -> gcd_out=2.
//  Exhaustive WIDTH=4: all 256 pairs vs reference model; check gcd_out, iter_cnt, exactly one done per accepted start.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared definitions for the sequential GCD engine: default operand width
// and the controller state encoding.
package gcd_pkg;

    localparam int GCD_WIDTH = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_CALC = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/gcd_sub_step.sv
// One Euclid subtraction step: compares the two operands and produces the
// pair for the next iteration (larger minus smaller, the other unchanged).
module gcd_sub_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             a_gt_b,
    output logic             b_gt_a,
    output logic             a_eq_b,
    output logic [WIDTH-1:0] a_next,
    output logic [WIDTH-1:0] b_next
);

    always_comb begin
        a_gt_b = (a > b);
        b_gt_a = (b > a);
        a_eq_b = (a == b);
        // Only the larger operand is reduced, so no step can underflow.
        a_next = a_gt_b ? (a - b) : a;
        b_next = b_gt_a ? (b - a) : b;
    end

endmodule

// File: rtl/gcd_seq_ctrl.sv
// Multi-cycle GCD engine: latches operands on start, performs one
// compare/subtract step per clock and reports the result with a done pulse.
module gcd_seq_ctrl
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH,
    parameter int CNT_W = WIDTH + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] gcd_out,
    output logic [CNT_W-1:0] iter_cnt
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] gcd_q, gcd_d;
    logic [CNT_W-1:0] iter_q, iter_d;

    logic             a_gt_b;
    logic             b_gt_a;
    logic             a_eq_b;
    logic [WIDTH-1:0] a_next;
    logic [WIDTH-1:0] b_next;

    gcd_sub_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .a      (a_q),
        .b      (b_q),
        .a_gt_b (a_gt_b),
        .b_gt_a (b_gt_a),
        .a_eq_b (a_eq_b),
        .a_next (a_next),
        .b_next (b_next)
    );

    // Reset clears every register, including an operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            gcd_q   <= '0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            gcd_q   <= gcd_d;
            iter_q  <= iter_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        gcd_d   = gcd_q;
        iter_d  = iter_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if ((a_in != '0) && (b_in != '0)) begin
                        a_d     = a_in;
                        b_d     = b_in;
                        cnt_d   = '0;
                        state_d = ST_CALC;
                    end else begin
                        // A zero operand short-circuits: gcd(x,0)=x, gcd(0,0)=0.
                        gcd_d   = a_in | b_in;
                        iter_d  = '0;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_CALC: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (a_eq_b) begin
                    gcd_d   = a_q;
                    iter_d  = cnt_q + CNT_W'(1);
                    state_d = ST_DONE;
                end else begin
                    a_d = a_next;
                    b_d = b_next;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The unused encoding is treated as IDLE, so it never reports busy.
    always_comb begin
        busy = (state_q == ST_CALC) || (state_q == ST_DONE);
        done = (state_q == ST_DONE);
    end

    assign gcd_out  = gcd_q;
    assign iter_cnt = iter_q;

endmodule

// File: tb/tb_gcd_seq_ctrl.sv
// Directed and exhaustive bench for gcd_seq_ctrl with an independent
// division-based Euclid reference model.
module tb_gcd_seq_ctrl;

    localparam int WIDTH = 4;
    localparam int CNT_W = WIDTH + 1;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] gcd_out;
    logic [CNT_W-1:0] iter_cnt;

    int total = 0;
    int bad   = 0;

    gcd_seq_ctrl #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .busy     (busy),
        .done     (done),
        .gcd_out  (gcd_out),
        .iter_cnt (iter_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // gcd by division; subtraction-loop iteration count equals the sum of quotients.
    function automatic void ref_gcd(input int a, input int b, output int g, output int it);
        int x, y, r;
        it = 0;
        if (a == 0 || b == 0) begin
            g = a | b;
        end else begin
            x = a;
            y = b;
            while (y != 0) begin
                it += x / y;
                r = x % y;
                x = y;
                y = r;
            end
            g = x;
        end
    endfunction

    // Issue one start, count edges (inclusive of the accept edge) until done,
    // count busy samples, and confirm done drops after one cycle.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          output int lat, output int busy_cyc, output logic done_after);
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        lat      = 1;
        busy_cyc = busy ? 1 : 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) busy_cyc++;
        end
        @(posedge clk);
        #1;
        done_after = done | busy;
    endtask

    initial begin
        int lat, bcyc, g, it, exp_lat;
        logic dflag;
        logic [WIDTH-1:0] g_hold;
        int extra_done;

        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_gcd", gcd_out, 0);
        chk("rst_iter", iter_cnt, 0);
        @(negedge clk);
        rst = 1'b0;

        run_op(4'd12, 4'd8, lat, bcyc, dflag);
        chk("12_8_gcd", gcd_out, 4);
        chk("12_8_iter", iter_cnt, 3);
        chk("12_8_lat", lat, 4);
        chk("12_8_pulse", dflag, 0);

        run_op(4'd15, 4'd1, lat, bcyc, dflag);
        chk("15_1_gcd", gcd_out, 1);
        chk("15_1_iter", iter_cnt, 15);
        chk("15_1_busy", bcyc, 16);
        chk("15_1_pulse", dflag, 0);

        run_op(4'd9, 4'd9, lat, bcyc, dflag);
        chk("9_9_gcd", gcd_out, 9);
        chk("9_9_iter", iter_cnt, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("9_9_hold", gcd_out, 9);

        run_op(4'd0, 4'd6, lat, bcyc, dflag);
        chk("0_6_gcd", gcd_out, 6);
        chk("0_6_iter", iter_cnt, 0);
        chk("0_6_lat", lat, 1);

        run_op(4'd0, 4'd0, lat, bcyc, dflag);
        chk("0_0_gcd", gcd_out, 0);
        chk("0_0_lat", lat, 1);

        // Start pulses during CALC and DONE must be ignored.
        @(negedge clk);
        a_in = 4'd14; b_in = 4'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a_in = 4'd3; b_in = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a_in = 4'd7; b_in = 4'd5;
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("ign_done_seen", done, 1);
        a_in = 4'd3; b_in = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        extra_done = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) extra_done++;
            @(negedge clk);
        end
        chk("ign_extra_done", extra_done, 0);
        chk("ign_gcd", gcd_out, 2);
        chk("ign_iter", iter_cnt, 5);

        // Reset in the 5th CALC cycle of (15,1).
        @(negedge clk);
        a_in = 4'd15; b_in = 4'd1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_gcd", gcd_out, 0);
        chk("mrst_iter", iter_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        run_op(4'd6, 4'd4, lat, bcyc, dflag);
        chk("6_4_gcd", gcd_out, 2);
        chk("6_4_iter", iter_cnt, 3);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                ref_gcd(a, b, g, it);
                exp_lat = (it == 0) ? 1 : it + 1;
                run_op(WIDTH'(a), WIDTH'(b), lat, bcyc, dflag);
                chk($sformatf("ex_%0d_%0d_gcd", a, b), gcd_out, g);
                chk($sformatf("ex_%0d_%0d_iter", a, b), iter_cnt, it);
                chk($sformatf("ex_%0d_%0d_lat", a, b), lat, exp_lat);
                chk($sformatf("ex_%0d_%0d_pulse", a, b), dflag, 0);
            end
        end

        g_hold = gcd_out;
        repeat (4) @(posedge clk);
        #1;
        chk("final_hold", gcd_out, g_hold);
        chk("final_gcd", gcd_out, 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
